r88_regseq: RTL and testbench
=============================

R88_REGSEQ -- requirements
Module: r88_regseq

Interface
REQ-001 TURN_CYCLES, default 1, idle bus-turnaround cycles between the last register-read capture and the first sequencer write (legal 1..3).
REQ-002 sysClock  input  1  single clock; all state updates on rising edge.
REQ-003 sysReset  input  1  reset, synchronous, active-high.
REQ-004 cmdValid  input  1  command request.
REQ-005 cmdReady  output  1  sequencer idle, command accepted when cmdValid&cmdReady.
REQ-006 cmdOp  input  2  00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
REQ-007 cmdSrc  input  4  source register number.
REQ-008 cmdDst  input  4  destination register number.
REQ-009 cmdData  input  8  write data (WRITE only).
REQ-010 rspValid  output  1  one-cycle completion pulse.
REQ-011 rspData  output  8  result byte, valid with rspValid.
REQ-012 regSel  output  1  register block select.
REQ-013 regAddr  output  4  register number for current access.
REQ-014 regRead  output  1  read strobe; register block drives extD on the following cycle.
REQ-015 regWrite  output  1  write strobe; register block captures extD at the same edge.
REQ-016 extD  inout  8  shared data bus; driven by sequencer only in write cycles.

Function
REQ-017 cmdReady SHALL be high only in IDLE; cmdOp/cmdSrc/cmdDst/cmdData SHALL be latched at acceptance, and cmdValid is ignored while busy.
REQ-018 RD(a) cycle: regSel=1, regRead=1, regAddr=a; CAP cycle: regSel=1, strobes 0, extD sampled at end of cycle.
REQ-019 WR(a,d) cycle: regSel=1, regWrite=1, regAddr=a, extD=d; TURN cycle: all strobes 0, extD high-Z.
REQ-020 READ: RD(src), CAP, RSP; rspData=captured byte; rspValid 3 cycles after acceptance.
REQ-021 WRITE: WR(dst,cmdData), RSP; rspData=cmdData; rspValid 2 cycles after acceptance.
REQ-022 MOVE: RD(src), CAP, TURN x TURN_CYCLES, WR(dst,captured), RSP; rspData=moved byte.
REQ-023 SWAP: RD(src), CAP, RD(dst), CAP, TURN x TURN_CYCLES, WR(src,oldDst), WR(dst,oldSrc), RSP; rspData=oldDst.
REQ-024 Reads SHALL be back-to-back without turnaround; writes SHALL never follow a CAP directly.
REQ-025 src==dst for MOVE/SWAP SHALL execute the full sequence, leaving the register value unchanged.
REQ-026 RSP returns to IDLE; the next command cannot be accepted before the following cycle (min. one idle bus cycle between commands).
REQ-027 regRead and regWrite SHALL never be high together; regSel=0 and regAddr=0 in IDLE, RSP and TURN.
REQ-028 rspValid SHALL be a single-cycle pulse with no backpressure.

Reset
REQ-029 While sysReset is high: state IDLE, cmdReady=0, rspValid=0, rspData=0, regSel=regRead=regWrite=0, regAddr=0, extD high-Z, temporaries 0.
REQ-030 Reset asserted mid-command SHALL abort at the next edge; no further strobe issues and no rspValid is produced.
REQ-031 cmdReady SHALL be high in the first cycle after sysReset deasserts.

Structure
REQ-032 Shared package r88_pkg SHALL hold cmdOp encodings, the sequencer state enumeration and the TURN_CYCLES default.
REQ-033 One sub-module, r88_busdrv (8-bit tri-state driver with enable), SHALL isolate extD driving.

Verification
REQ-034 Bench model: r88_regblock with regs preloaded R3=0x5A, R7=0xC3.
REQ-035 READ src=3 -> RD/CAP on regAddr=3; rspValid at accept+3 with rspData=0x5A.
REQ-036 WRITE dst=9 data=0xA5 -> single regWrite with extD=0xA5 at accept+1; rspValid at accept+2; subsequent READ 9 returns 0xA5.
REQ-037 SWAP src=3 dst=7, TURN_CYCLES=2 -> two CAPs, two TURN cycles with extD high-Z, then R3=0xC3, R7=0x5A; rspData=0xC3 at accept+9.
REQ-038 MOVE src=7 dst=7 -> full sequence, R7 remains 0xC3; cmdValid held high throughout -> second command accepted only after RSP plus one idle cycle.
REQ-039 sysReset pulsed during SWAP TURN -> no regWrite issued, rspValid stays 0, R3/R7 unchanged, cmdReady=1 in first cycle after release.

Source files
------------

// File: rtl/r88_pkg.sv
// Shared definitions for the r88 register sequencer: command opcodes,
// sequencer states and the default bus-turnaround length.
package r88_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_SWAP  = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD1,
        ST_CAP1,
        ST_RD2,
        ST_CAP2,
        ST_TURN,
        ST_WR1,
        ST_WR2,
        ST_RSP
    } state_e;

    localparam int unsigned TURN_CYCLES_DEF = 1;

endpackage

// File: rtl/r88_busdrv.sv
// Tri-state driver that is the only place the shared data bus gets driven.
module r88_busdrv #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] d,
    inout  wire  [W-1:0] bus
);

    assign bus = en ? d : {W{1'bz}};

endmodule

// File: rtl/r88_regseq.sv
// Register-block sequencer: turns READ/WRITE/MOVE/SWAP commands into
// RD/CAP/TURN/WR bus cycles on a shared tri-state data bus and returns a
// single-cycle response. All outputs are forced low while sysReset is high
// so an in-flight command is silenced immediately and dropped at the edge.
module r88_regseq
    import r88_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = TURN_CYCLES_DEF
) (
    input  logic       sysClock,
    input  logic       sysReset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [1:0] cmdOp,
    input  logic [3:0] cmdSrc,
    input  logic [3:0] cmdDst,
    input  logic [7:0] cmdData,
    output logic       rspValid,
    output logic [7:0] rspData,
    output logic       regSel,
    output logic [3:0] regAddr,
    output logic       regRead,
    output logic       regWrite,
    inout  wire  [7:0] extD
);

    // Turnaround counter reload: counts TURN_CYCLES-1 down to zero.
    localparam logic [1:0] TURN_LOAD = 2'(TURN_CYCLES - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [3:0]  src_q, src_d;
    logic [3:0]  dst_q, dst_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  tmp_a_q, tmp_a_d;   // first captured byte (source register)
    logic [7:0]  tmp_b_q, tmp_b_d;   // second captured byte (SWAP destination)
    logic [1:0]  turn_q, turn_d;

    logic        drive_en;
    logic [7:0]  wdata;

    // Next-state logic: command latch, capture of read data, turnaround count.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        tmp_a_d = tmp_a_q;
        tmp_b_d = tmp_b_q;
        turn_d  = turn_q;
        case (state_q)
            ST_IDLE: begin
                if (cmdValid) begin
                    op_d    = op_e'(cmdOp);
                    src_d   = cmdSrc;
                    dst_d   = cmdDst;
                    data_d  = cmdData;
                    state_d = (op_e'(cmdOp) == OP_WRITE) ? ST_WR1 : ST_RD1;
                end
            end
            ST_RD1:  state_d = ST_CAP1;
            ST_CAP1: begin
                tmp_a_d = extD;
                if (op_q == OP_SWAP) begin
                    state_d = ST_RD2;
                end else if (op_q == OP_READ) begin
                    state_d = ST_RSP;
                end else begin
                    turn_d  = TURN_LOAD;
                    state_d = ST_TURN;
                end
            end
            ST_RD2:  state_d = ST_CAP2;
            ST_CAP2: begin
                tmp_b_d = extD;
                turn_d  = TURN_LOAD;
                state_d = ST_TURN;
            end
            ST_TURN: begin
                if (turn_q == 2'd0) begin
                    state_d = ST_WR1;
                end else begin
                    turn_d = turn_q - 2'd1;
                end
            end
            ST_WR1:  state_d = (op_q == OP_SWAP) ? ST_WR2 : ST_RSP;
            ST_WR2:  state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and temporaries register; reset clears everything and aborts.
    always_ff @(posedge sysClock) begin
        if (sysReset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            src_q   <= 4'd0;
            dst_q   <= 4'd0;
            data_q  <= 8'd0;
            tmp_a_q <= 8'd0;
            tmp_b_q <= 8'd0;
            turn_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
            turn_q  <= turn_d;
        end
    end

    // Bus-cycle and response outputs decoded from the current state.
    always_comb begin
        cmdReady = 1'b0;
        rspValid = 1'b0;
        rspData  = 8'd0;
        regSel   = 1'b0;
        regAddr  = 4'd0;
        regRead  = 1'b0;
        regWrite = 1'b0;
        drive_en = 1'b0;
        wdata    = 8'd0;
        if (!sysReset) begin
            case (state_q)
                ST_IDLE: cmdReady = 1'b1;
                ST_RD1: begin
                    regSel  = 1'b1;
                    regRead = 1'b1;
                    regAddr = src_q;
                end
                ST_CAP1: begin
                    regSel  = 1'b1;
                    regAddr = src_q;
                end
                ST_RD2: begin
                    regSel  = 1'b1;
                    regRead = 1'b1;
                    regAddr = dst_q;
                end
                ST_CAP2: begin
                    regSel  = 1'b1;
                    regAddr = dst_q;
                end
                ST_WR1: begin
                    regSel   = 1'b1;
                    regWrite = 1'b1;
                    drive_en = 1'b1;
                    // SWAP writes the old destination into the source first.
                    regAddr  = (op_q == OP_SWAP) ? src_q : dst_q;
                    if (op_q == OP_WRITE) begin
                        wdata = data_q;
                    end else if (op_q == OP_SWAP) begin
                        wdata = tmp_b_q;
                    end else begin
                        wdata = tmp_a_q;
                    end
                end
                ST_WR2: begin
                    regSel   = 1'b1;
                    regWrite = 1'b1;
                    drive_en = 1'b1;
                    regAddr  = dst_q;
                    wdata    = tmp_a_q;
                end
                ST_RSP: begin
                    rspValid = 1'b1;
                    if (op_q == OP_WRITE) begin
                        rspData = data_q;
                    end else if (op_q == OP_SWAP) begin
                        rspData = tmp_b_q;
                    end else begin
                        rspData = tmp_a_q;
                    end
                end
                default: ;
            endcase
        end
    end

    r88_busdrv #(.W(8)) u_busdrv (
        .en  (drive_en),
        .d   (wdata),
        .bus (extD)
    );

endmodule

// File: tb/tb_r88_regseq.sv
// Bench for r88_regseq: a reactive register block on the shared bus, a
// per-cycle expected-bus-activity queue built from the command rules, and
// literal checks on response data, latency and register contents.
module tb_r88_regseq;
    import r88_pkg::*;

    localparam int          TURN  = 2;
    localparam logic [7:0]  PROBE = 8'h3C;

    typedef struct packed {
        logic       rdy;
        logic       sel;
        logic       rd;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       rspv;
        logic [7:0] rspd;
    } exp_t;

    logic       sysClock = 1'b0;
    logic       sysReset = 1'b1;
    logic       cmdValid = 1'b0;
    logic [1:0] cmdOp    = 2'd0;
    logic [3:0] cmdSrc   = 4'd0;
    logic [3:0] cmdDst   = 4'd0;
    logic [7:0] cmdData  = 8'd0;
    logic       cmdReady;
    logic       rspValid;
    logic [7:0] rspData;
    logic       regSel;
    logic [3:0] regAddr;
    logic       regRead;
    logic       regWrite;
    wire  [7:0] extD;

    logic [7:0] rb_mem [16];
    logic       rb_drv = 1'b0;
    logic [7:0] rb_q   = 8'd0;
    logic [7:0] mregs  [16];

    exp_t       expq[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    int         acc_cyc = 0;
    int         last_lat = 0;
    int         rsp_cnt = 0;
    logic [7:0] last_rsp = 8'd0;

    r88_regseq #(.TURN_CYCLES(TURN)) dut (
        .sysClock (sysClock),
        .sysReset (sysReset),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdOp    (cmdOp),
        .cmdSrc   (cmdSrc),
        .cmdDst   (cmdDst),
        .cmdData  (cmdData),
        .rspValid (rspValid),
        .rspData  (rspData),
        .regSel   (regSel),
        .regAddr  (regAddr),
        .regRead  (regRead),
        .regWrite (regWrite),
        .extD     (extD)
    );

    always #5 sysClock = ~sysClock;

    // Register block drives read data the cycle after RD; otherwise, when
    // nobody should be driving, the bench puts a probe value on the bus so
    // any stray sequencer drive shows up as a corrupted probe.
    assign extD = rb_drv ? rb_q : (!regWrite ? PROBE : 8'hzz);

    initial begin
        for (int i = 0; i < 16; i++) begin
            rb_mem[i] = 8'd0;
            mregs[i]  = 8'd0;
        end
        rb_mem[3] = 8'h5A;
        rb_mem[7] = 8'hC3;
        mregs[3]  = 8'h5A;
        mregs[7]  = 8'hC3;
    end

    always @(posedge sysClock) begin
        cyc <= cyc + 1;
        if (regSel && regWrite) rb_mem[regAddr] <= extD;
        rb_drv <= regSel && regRead;
        rb_q   <= rb_mem[regAddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic exp_t ent(input logic rdy, input logic sel, input logic rd,
                                 input logic wr, input logic [3:0] addr,
                                 input logic [7:0] wd, input logic rv,
                                 input logic [7:0] rdat);
        exp_t e;
        e.rdy = rdy; e.sel = sel; e.rd = rd; e.wr = wr; e.addr = addr;
        e.wdata = wd; e.rspv = rv; e.rspd = rdat;
        return e;
    endfunction

    // Expected bus activity of one command, starting with its accept cycle.
    task automatic push_cmd(input logic [1:0] op, input logic [3:0] s,
                            input logic [3:0] d, input logic [7:0] data,
                            input bit commit);
        logic [7:0] vs;
        logic [7:0] vd;
        vs = mregs[s];
        vd = mregs[d];
        expq.push_back(ent(1, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            2'b00: begin
                expq.push_back(ent(0, 1, 1, 0, s, 0, 0, 0));
                expq.push_back(ent(0, 1, 0, 0, s, 0, 0, 0));
                expq.push_back(ent(0, 0, 0, 0, 0, 0, 1, vs));
            end
            2'b01: begin
                expq.push_back(ent(0, 1, 0, 1, d, data, 0, 0));
                expq.push_back(ent(0, 0, 0, 0, 0, 0, 1, data));
                if (commit) mregs[d] = data;
            end
            2'b10: begin
                expq.push_back(ent(0, 1, 1, 0, s, 0, 0, 0));
                expq.push_back(ent(0, 1, 0, 0, s, 0, 0, 0));
                for (int t = 0; t < TURN; t++) expq.push_back(ent(0, 0, 0, 0, 0, 0, 0, 0));
                expq.push_back(ent(0, 1, 0, 1, d, vs, 0, 0));
                expq.push_back(ent(0, 0, 0, 0, 0, 0, 1, vs));
                if (commit) mregs[d] = vs;
            end
            default: begin
                expq.push_back(ent(0, 1, 1, 0, s, 0, 0, 0));
                expq.push_back(ent(0, 1, 0, 0, s, 0, 0, 0));
                expq.push_back(ent(0, 1, 1, 0, d, 0, 0, 0));
                expq.push_back(ent(0, 1, 0, 0, d, 0, 0, 0));
                for (int t = 0; t < TURN; t++) expq.push_back(ent(0, 0, 0, 0, 0, 0, 0, 0));
                expq.push_back(ent(0, 1, 0, 1, s, vd, 0, 0));
                expq.push_back(ent(0, 1, 0, 1, d, vs, 0, 0));
                expq.push_back(ent(0, 0, 0, 0, 0, 0, 1, vd));
                if (commit) begin
                    mregs[s] = vd;
                    mregs[d] = vs;
                end
            end
        endcase
    endtask

    // Per-cycle compare of every DUT output against the expected activity.
    always @(negedge sysClock) begin
        exp_t e;
        if (sysReset) e = '0;
        else if (expq.size() != 0) e = expq.pop_front();
        else e = ent(1, 0, 0, 0, 0, 0, 0, 0);
        chk("cmdReady", 32'(cmdReady), 32'(e.rdy));
        chk("regSel",   32'(regSel),   32'(e.sel));
        chk("regRead",  32'(regRead),  32'(e.rd));
        chk("regWrite", 32'(regWrite), 32'(e.wr));
        chk("regAddr",  32'(regAddr),  32'(e.addr));
        chk("rspValid", 32'(rspValid), 32'(e.rspv));
        chk("rspData",  32'(rspData),  32'(e.rspd));
        if (e.wr) chk("extD_write", 32'(extD), 32'(e.wdata));
        else if (!rb_drv) chk("extD_released", 32'(extD), 32'(PROBE));
        if (rspValid) begin
            last_rsp = rspData;
            last_lat = cyc - acc_cyc;
            rsp_cnt++;
        end
    end

    // Issue one command at the start of an idle cycle; return at the start
    // of the next idle cycle. Fields are scrambled after acceptance.
    task automatic send(input logic [1:0] op, input logic [3:0] s, input logic [3:0] d,
                        input logic [7:0] data, input bit hold);
        int n;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdSrc   = s;
        cmdDst   = d;
        cmdData  = data;
        acc_cyc  = cyc;
        push_cmd(op, s, d, data, 1'b1);
        @(posedge sysClock); #2;
        if (!hold) cmdValid = 1'b0;
        cmdOp   = ~op;
        cmdSrc  = s + 4'd1;
        cmdDst  = d + 4'd2;
        cmdData = ~data;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            @(posedge sysClock); #2;
            n++;
        end
        if (expq.size() != 0) begin
            chk("cmd_timeout", 32'(expq.size()), 32'd0);
            expq.delete();
        end
    endtask

    initial begin
        int rsp_before;
        sysReset = 1'b1;
        repeat (3) @(posedge sysClock);
        #2 sysReset = 1'b0;
        @(posedge sysClock); #2;

        send(OP_READ, 4'd3, 4'd0, 8'h00, 1'b0);
        chk("read3_data", 32'(last_rsp), 32'h5A);
        chk("read3_lat", 32'(last_lat), 32'd3);

        send(OP_WRITE, 4'd0, 4'd9, 8'hA5, 1'b0);
        chk("write9_lat", 32'(last_lat), 32'd2);
        chk("write9_mem", 32'(rb_mem[9]), 32'hA5);

        send(OP_READ, 4'd9, 4'd0, 8'h00, 1'b0);
        chk("read9_data", 32'(last_rsp), 32'hA5);

        send(OP_MOVE, 4'd3, 4'd5, 8'h00, 1'b0);
        chk("move35_data", 32'(last_rsp), 32'h5A);
        chk("move35_lat", 32'(last_lat), 32'd6);
        chk("move35_mem", 32'(rb_mem[5]), 32'h5A);

        send(OP_MOVE, 4'd7, 4'd7, 8'h00, 1'b1);
        chk("move77_mem", 32'(rb_mem[7]), 32'hC3);
        send(OP_READ, 4'd7, 4'd0, 8'h00, 1'b0);
        chk("read7_after_hold", 32'(last_rsp), 32'hC3);
        chk("read7_lat", 32'(last_lat), 32'd3);

        send(OP_SWAP, 4'd3, 4'd7, 8'h00, 1'b0);
        chk("swap_data", 32'(last_rsp), 32'hC3);
        chk("swap_lat", 32'(last_lat), 32'd9);
        chk("swap_r3", 32'(rb_mem[3]), 32'hC3);
        chk("swap_r7", 32'(rb_mem[7]), 32'h5A);

        send(OP_SWAP, 4'd3, 4'd3, 8'h00, 1'b0);
        chk("swap33_data", 32'(last_rsp), 32'hC3);
        chk("swap33_r3", 32'(rb_mem[3]), 32'hC3);

        // SWAP aborted by reset in its first turnaround cycle.
        rsp_before = rsp_cnt;
        cmdValid = 1'b1;
        cmdOp    = OP_SWAP;
        cmdSrc   = 4'd3;
        cmdDst   = 4'd7;
        cmdData  = 8'h00;
        push_cmd(OP_SWAP, 4'd3, 4'd7, 8'h00, 1'b0);
        while (expq.size() > 5) void'(expq.pop_back());
        @(posedge sysClock); #2;
        cmdValid = 1'b0;
        repeat (4) @(posedge sysClock);
        #2 sysReset = 1'b1;
        @(posedge sysClock);
        #2 sysReset = 1'b0;
        repeat (4) @(posedge sysClock);
        #2;
        chk("abort_no_rsp", 32'(rsp_cnt - rsp_before), 32'd0);
        chk("abort_r3", 32'(rb_mem[3]), 32'hC3);
        chk("abort_r7", 32'(rb_mem[7]), 32'h5A);

        send(OP_READ, 4'd3, 4'd0, 8'h00, 1'b0);
        chk("read3_final", 32'(last_rsp), 32'hC3);
        send(OP_READ, 4'd7, 4'd0, 8'h00, 1'b0);
        chk("read7_final", 32'(last_rsp), 32'h5A);

        for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), 32'(rb_mem[i]), 32'(mregs[i]));

        @(posedge sysClock); #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
